// File: rtl/battery_manager.sv
// -----------------------------------------------------------------------------
// battery_manager
//
// Debounces a per-channel "battery empty" flag from sampled levels and runs a
// round-robin selector that keeps one usable battery active.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst          : asynchronous, active-high reset
//   sample_en    : batt_level carries a valid sample this cycle
//   batt_level   : N_BATT unsigned levels, channel i at [i*WIDTH +: WIDTH]
//   is_empty     : debounced empty flag per channel (1 = empty)
//   full_state   : every channel is non-empty
//   active_sel   : index of the selected battery
//   active_valid : active_sel names a usable battery (RUN state only)
//   switch_pulse : one-cycle strobe when active_sel is loaded
//   depleted     : no usable battery was found
//   low_warn     : (BATT_LOW_WARN_EN only) active level <= LOW_LVL at the
//                  last sample while active_valid was high
//
// Optional feature macro: BATT_LOW_WARN_EN
// -----------------------------------------------------------------------------
module battery_manager #(
  parameter int N_BATT      = 2,
  parameter int WIDTH       = 4,
  parameter int EMPTY_LVL   = 0,
  parameter int RECOVER_LVL = 2,
  parameter int DEBOUNCE    = 3,
  parameter int LOW_LVL     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sample_en,
  input  logic [N_BATT*WIDTH-1:0]   batt_level,
  output logic [N_BATT-1:0]         is_empty,
  output logic                      full_state,
  output logic [$clog2(N_BATT)-1:0] active_sel,
  output logic                      active_valid,
  output logic                      switch_pulse,
  output logic                      depleted
`ifdef BATT_LOW_WARN_EN
  ,
  output logic                      low_warn
`endif
);

  localparam int SEL_W = $clog2(N_BATT);
  localparam int CNT_W = 4;  // DEBOUNCE is at most 15

  localparam logic [WIDTH-1:0] EMPTY_L   = WIDTH'(EMPTY_LVL);
  localparam logic [WIDTH-1:0] RECOVER_L = WIDTH'(RECOVER_LVL);
  // Counter value at which the next qualifying sample completes the debounce.
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, SWITCH, RUN, DEPLETED} state_t;

  // ---------------------------------------------------------------------------
  // Debounce: one counter per channel counting consecutive samples that argue
  // for flipping the flag; anything else restarts the count. The gap between
  // EMPTY_LVL and RECOVER_LVL never qualifies, giving hysteresis.
  // ---------------------------------------------------------------------------
  logic [N_BATT-1:0] is_empty_q, is_empty_d;
  logic [CNT_W-1:0]  cnt_q [N_BATT];
  logic [CNT_W-1:0]  cnt_d [N_BATT];
  logic [WIDTH-1:0]  lvl;
  logic              qual;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    is_empty_d = is_empty_q;
    lvl        = '0;
    qual       = 1'b0;
    for (int i = 0; i < N_BATT; i++) begin
      cnt_d[i] = cnt_q[i];
      lvl      = batt_level[i*WIDTH +: WIDTH];
      qual     = is_empty_q[i] ? (lvl >= RECOVER_L) : (lvl <= EMPTY_L);
      if (sample_en) begin
        if (!qual) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] >= DEB_LAST) begin
          is_empty_d[i] = ~is_empty_q[i];
          cnt_d[i]      = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin search: first non-empty channel starting at search_base_q.
  // search_base_q is (active_sel+1) mod N_BATT, or 0 when leaving IDLE, so the
  // current channel is always tested last.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] search_base_q, search_base_d;
  logic [SEL_W-1:0] found_idx;
  logic             found;
  logic [SEL_W:0]   cand;

  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_BATT; k++) begin
      cand = {1'b0, search_base_q} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(N_BATT)) cand = cand - (SEL_W+1)'(N_BATT);
      if (!found && !is_empty_q[cand[SEL_W-1:0]]) begin
        found     = 1'b1;
        found_idx = cand[SEL_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller FSM; all outputs are registered from the next-state values.
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  logic [SEL_W-1:0] next_base;
  logic             active_valid_q, active_valid_d;
  logic             switch_pulse_q, switch_pulse_d;
  logic             depleted_q, depleted_d;
  logic             any_ready;

  assign any_ready = |(~is_empty_q);
  assign next_base = (active_sel_q == SEL_W'(N_BATT - 1)) ? '0
                                                          : active_sel_q + SEL_W'(1);

  always_comb begin
    state_d       = state_q;
    active_sel_d  = active_sel_q;
    search_base_d = search_base_q;
    unique case (state_q)
      IDLE: begin
        if (any_ready) begin
          state_d       = SWITCH;
          search_base_d = '0;
        end
      end
      SWITCH: begin
        if (found) begin
          state_d      = RUN;
          active_sel_d = found_idx;
        end else begin
          state_d = DEPLETED;
        end
      end
      RUN: begin
        // Only the active channel matters; other flags are ignored here.
        if (is_empty_q[active_sel_q]) begin
          state_d       = SWITCH;
          search_base_d = next_base;
        end
      end
      DEPLETED: begin
        if (any_ready) begin
          state_d       = SWITCH;
          search_base_d = next_base;
        end
      end
      default: state_d = IDLE;
    endcase
    switch_pulse_d = (state_q == SWITCH) && found;
    active_valid_d = (state_d == RUN);
    depleted_d     = (state_d == DEPLETED);
  end

`ifdef BATT_LOW_WARN_EN
  localparam logic [WIDTH-1:0] LOW_L = WIDTH'(LOW_LVL);
  logic low_warn_q, low_warn_d;

  // Judged against the outputs as they stand at the sample, held in between.
  always_comb begin
    low_warn_d = low_warn_q;
    if (sample_en) begin
      low_warn_d = active_valid_q &&
                   (batt_level[active_sel_q*WIDTH +: WIDTH] <= LOW_L);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) low_warn_q <= 1'b0;
    else     low_warn_q <= low_warn_d;
  end

  assign low_warn = low_warn_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_empty_q     <= '1;
      // NOTE: the counter array is small and its reset value is observable
      // (restart after reset), so it is reset like any other flop.
      for (int i = 0; i < N_BATT; i++) cnt_q[i] <= '0;
      state_q        <= IDLE;
      active_sel_q   <= '0;
      search_base_q  <= '0;
      active_valid_q <= 1'b0;
      switch_pulse_q <= 1'b0;
      depleted_q     <= 1'b0;
    end else begin
      is_empty_q     <= is_empty_d;
      for (int i = 0; i < N_BATT; i++) cnt_q[i] <= cnt_d[i];
      state_q        <= state_d;
      active_sel_q   <= active_sel_d;
      search_base_q  <= search_base_d;
      active_valid_q <= active_valid_d;
      switch_pulse_q <= switch_pulse_d;
      depleted_q     <= depleted_d;
    end
  end

  assign is_empty     = is_empty_q;
  assign full_state   = &(~is_empty_q);
  assign active_sel   = active_sel_q;
  assign active_valid = active_valid_q;
  assign switch_pulse = switch_pulse_q;
  assign depleted     = depleted_q;

endmodule

// File: doc/battery_manager.md
BATTERY_MANAGER -- requirements
Module: battery_manager

Interface
REQ-001 SHALL have parameter N_BATT, default 2: number of battery channels, 2..8.
REQ-002 SHALL have parameter WIDTH, default 4: level bits per channel.
REQ-003 SHALL have parameter EMPTY_LVL, default 0: a level at or below this is an empty sample.
REQ-004 SHALL have parameter RECOVER_LVL, default 2: a level at or above this is a recovered sample; must be greater than EMPTY_LVL.
REQ-005 SHALL have parameter DEBOUNCE, default 3: consecutive qualifying samples needed to change a flag, 1..15.
REQ-006 SHALL have parameter LOW_LVL, default 3: low-warning threshold; used only with BATT_LOW_WARN_EN.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port sample_en, input, 1 bit: the levels are a valid sample this cycle.
REQ-010 SHALL have port batt_level, input, N_BATT*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH], unsigned.
REQ-011 SHALL have port is_empty, output, N_BATT bits: debounced empty flag per channel.
REQ-012 SHALL have port full_state, output, 1 bit: all channels non-empty, which is the AND of ~is_empty.
REQ-013 SHALL have port active_sel, output, clog2(N_BATT) bits: index of the selected battery.
REQ-014 SHALL have port active_valid, output, 1 bit: active_sel names a usable battery.
REQ-015 SHALL have port switch_pulse, output, 1 bit: one-cycle strobe when active_sel is loaded.
REQ-016 SHALL have port depleted, output, 1 bit: no usable battery.

Function
REQ-017 SHALL keep a saturating debounce counter per channel, updated only when sample_en=1.
REQ-018 While is_empty[i]=0, each sample with level <= EMPTY_LVL SHALL increment the counter, and any other sample SHALL clear it.
REQ-019 While is_empty[i]=1, each sample with level >= RECOVER_LVL SHALL increment the counter, and any other sample SHALL clear it.
REQ-020 When a sample brings the counter to DEBOUNCE, is_empty[i] SHALL toggle on that same edge and the counter SHALL clear.
REQ-021 Levels between EMPTY_LVL and RECOVER_LVL SHALL never change a flag (hysteresis).
REQ-022 The controller SHALL be an FSM with states IDLE, SWITCH, RUN and DEPLETED.
REQ-023 In IDLE, if any is_empty bit is 0, the FSM SHALL go to SWITCH with the search starting at index 0 inclusive.
REQ-024 In SWITCH, the FSM SHALL search in round-robin order for the first channel with is_empty=0.
REQ-025 The SWITCH search SHALL start at (active_sel+1) mod N_BATT and test active_sel last.
REQ-026 If SWITCH finds a channel, it SHALL load active_sel, assert switch_pulse for exactly one cycle and go to RUN.
REQ-027 If SWITCH finds no channel, the FSM SHALL go to DEPLETED.
REQ-028 In RUN, active_valid SHALL be 1, and is_empty[active_sel]=1 SHALL cause a transition to SWITCH.
REQ-029 In DEPLETED, depleted SHALL be 1, active_valid SHALL be 0, and any is_empty bit at 0 SHALL cause a transition to SWITCH.
REQ-030 Outside RUN, active_valid SHALL be 0, including during the SWITCH cycle.
REQ-031 Latency from the qualifying sample edge to switch_pulse SHALL be 2 cycles: flag on edge 0, SWITCH on edge 1, pulse on edge 2.
REQ-032 If several channels go empty on the same edge, the REQ-025 search order SHALL resolve which channel is chosen.
REQ-033 A flag change on a non-active channel during RUN SHALL NOT cause a switch.

Reset
REQ-034 On rst=1, asynchronously: is_empty SHALL be all 1s, counters 0, state IDLE, active_sel 0, and active_valid, switch_pulse, full_state and low_warn 0.
REQ-035 On rst=1, depleted SHALL be 0.
REQ-036 Reset asserted mid-operation SHALL override all in-flight debounce and switch activity, with no output glitch after release.

Configuration
REQ-037 With macro BATT_LOW_WARN_EN defined, the block SHALL add output port low_warn, 1 bit.
REQ-038 With BATT_LOW_WARN_EN defined, low_warn SHALL be registered and equal 1 when active_valid=1 and the active level <= LOW_LVL on a sample_en cycle.
REQ-039 With BATT_LOW_WARN_EN defined, low_warn SHALL hold its value between samples.
REQ-040 Without BATT_LOW_WARN_EN, the low_warn port and its logic SHALL be absent, with all other behaviour identical.

Verification (N_BATT=2, WIDTH=4, EMPTY_LVL=0, RECOVER_LVL=2, DEBOUNCE=3, LOW_LVL=3)
REQ-041 Reset, then A=7, B=7 for 3 samples -> is_empty=00 after the 3rd sample, active_sel=0, switch_pulse once, full_state=1.
REQ-042 In RUN on A, A=0 for 3 samples -> is_empty[0]=1, 2 cycles later active_sel=1 with a single switch_pulse, and active_valid low for exactly the SWITCH cycle.
REQ-043 A=0, B=0 for 3 samples -> depleted=1 and active_valid=0; then B=3 for 3 samples -> active_sel=1, depleted=0.
REQ-044 A toggling 0,1,0 each sample and then 1 or 2 -> no flag change (counter cleared), showing the hysteresis band.
REQ-045 rst asserted between the 2nd and 3rd empty sample -> all outputs return to reset values immediately and the counter restarts from 0.
REQ-046 With BATT_LOW_WARN_EN, active A=12 then A=3 -> low_warn goes 0 then 1 on the sample edge.
